mips_multicycle_ctrl: RTL
=========================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port enable, input, 1: permits leaving IDLE and starting the next instruction.
REQ-005 SHALL have port opcode, input, 6: instruction bits 31:26 from the external instruction register; valid from DECODE onward.
REQ-006 SHALL have port funct, input, 6: instruction bits 5:0, same validity as opcode.
REQ-007 SHALL have port zero, input, 1: ALU zero flag.
REQ-008 SHALL have outputs IorD, IRWrite, PCWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, each 1 bit: datapath strobes and mux selects.
REQ-009 SHALL have outputs PCSrc (2), ALUSrcB (2), ALUControl (3): datapath mux selects and ALU operation.
REQ-010 SHALL have outputs state (3), instr_done (1), illegal (1), instr_count (COUNT_WIDTH).

Function
REQ-011 SHALL use the state encoding IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5; state output SHALL equal the current state.
REQ-012 SHALL support the following instructions: R-type (opcode 0x00; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
REQ-013 SHALL encode ALUControl as: add 010, sub 110, and 000, or 001, slt 111.
REQ-014 SHALL make the following transitions: IDLE->FETCH when enable=1, otherwise hold IDLE.
REQ-015 SHALL make the following transitions: FETCH->DECODE always.
REQ-016 SHALL make the following transitions: DECODE->EXECUTE for supported codes, otherwise DECODE->next.
REQ-017 SHALL make the following transitions: EXECUTE->WRITEBACK for R-type and addi, EXECUTE->MEM for lw and sw, EXECUTE->next for beq, bne and j.
REQ-018 SHALL make the following transitions: MEM->WRITEBACK for lw, MEM->next for sw; WRITEBACK->next.
REQ-019 SHALL define "next" as FETCH if enable=1, else IDLE.
REQ-020 SHALL treat an unsupported opcode, or an unsupported funct with opcode 0x00, as illegal.
REQ-021 SHALL default every output not listed for the current state to 0; the outputs SHALL be Moore outputs of state and opcode/funct, except PCWrite in EXECUTE, which also uses zero.
REQ-022 SHALL drive in FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00, PCWrite=1.
REQ-023 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add (branch target precompute).
REQ-024 SHALL drive in EXECUTE for R-type: ALUSrcA=1, ALUSrcB=00, ALUControl per funct.
REQ-025 SHALL drive in EXECUTE for addi, lw and sw: ALUSrcA=1, ALUSrcB=10, add.
REQ-026 SHALL drive in EXECUTE for beq: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=zero.
REQ-027 SHALL drive in EXECUTE for bne: same as beq except PCWrite=~zero.
REQ-028 SHALL drive in EXECUTE for j: PCSrc=10, PCWrite=1.
REQ-029 SHALL drive in MEM: IorD=1; MemWrite=1 only for sw.
REQ-030 SHALL drive in WRITEBACK: RegWrite=1; RegDst=1 for R-type, 0 otherwise; MemtoReg=1 for lw, 0 otherwise.
REQ-031 SHALL assert instr_done for exactly one cycle, the final state of each supported instruction (WRITEBACK, MEM-sw, or EXECUTE-branch/j).
REQ-032 SHALL increment instr_count by 1 in the same cycle as instr_done and wrap from all-ones to 0.
REQ-033 SHALL assert illegal for exactly the one DECODE cycle of an illegal instruction, with no write strobe active, no instr_done and no instr_count change.
REQ-034 SHALL ignore enable changes outside IDLE and "next" decisions; an instruction in progress always completes.
REQ-035 SHALL never assert more than one of MemWrite and RegWrite in the same cycle, and never assert IRWrite outside FETCH.

Reset
REQ-036 SHALL, with reset=0 at a rising edge, force state=IDLE and instr_count=0 on that edge, regardless of current state.
REQ-037 SHALL hold all strobes at 0 and all selects at 0 while reset=0 and in IDLE.
REQ-038 SHALL abandon an instruction interrupted by reset mid-operation, with no further strobes and no instr_done.

Verification
REQ-039 SHALL be verified for addi (0x22100005, opcode 0x08), enable=1: states 1,2,3,5,1; RegWrite=1 with RegDst=0 and MemtoReg=0 only in WRITEBACK; instr_count 0->1.
REQ-040 SHALL be verified for beq (0x12110002): with zero=1, EXECUTE shows PCSrc=01, PCWrite=1, ALUControl=110, then FETCH; repeat with zero=0 -> PCWrite=0; bne with zero=0 -> PCWrite=1.
REQ-041 SHALL be verified for j (0x08100002): states 1,2,3,1; EXECUTE shows PCSrc=10, PCWrite=1; instr_done=1 in EXECUTE.
REQ-042 SHALL be verified for lw then sw: lw states 1,2,3,4,5 with IorD=1 in MEM and MemtoReg=1 in WRITEBACK; sw states 1,2,3,4 then 1, with MemWrite=1 only in MEM.
REQ-043 SHALL be verified for opcode 0x3F and for R-type funct 0x07: illegal=1 in DECODE, then FETCH, with no write strobes and instr_count unchanged.
REQ-044 SHALL be verified for reset=0 during MEM of sw: next cycle state=0 with MemWrite=0 and instr_count=0; a second case preloads instr_count=0xFFFF, retires one instruction and checks instr_count=0x0000; a third case drops enable in WRITEBACK and checks state=IDLE.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: six-state Moore FSM that sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   IorD,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   ALUSrcA,
    output logic [1:0]             PCSrc,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUControl,
    output logic [2:0]             state,
    output logic                   instr_done,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    state_t                 w_after_instr;
    logic [COUNT_WIDTH-1:0] r_instr_count;

    logic       w_is_rtype;
    logic       w_is_addi;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_j;
    logic       w_funct_ok;
    logic       w_legal;
    logic [2:0] w_rtype_alu;

    logic       w_iord;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_alusrca;
    logic [1:0] w_pcsrc;
    logic [1:0] w_alusrcb;
    logic [2:0] w_aluctl;
    logic       w_done;
    logic       w_illegal;

    assign w_is_rtype = (opcode == OP_RTYPE);
    assign w_is_addi  = (opcode == OP_ADDI);
    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_is_beq   = (opcode == OP_BEQ);
    assign w_is_bne   = (opcode == OP_BNE);
    assign w_is_j     = (opcode == OP_J);

    always_comb begin
        w_funct_ok  = 1'b1;
        w_rtype_alu = ALU_ADD;
        case (funct)
            FN_ADD:  w_rtype_alu = ALU_ADD;
            FN_SUB:  w_rtype_alu = ALU_SUB;
            FN_AND:  w_rtype_alu = ALU_AND;
            FN_OR:   w_rtype_alu = ALU_OR;
            FN_SLT:  w_rtype_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    assign w_legal = (w_is_rtype & w_funct_ok) | w_is_addi | w_is_lw | w_is_sw |
                     w_is_beq | w_is_bne | w_is_j;

    // Where every finished (or rejected) instruction goes: straight on, or park.
    assign w_after_instr = enable ? S_FETCH : S_IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    w_next_state = enable ? S_FETCH : S_IDLE;
            S_FETCH:   w_next_state = S_DECODE;
            S_DECODE:  w_next_state = w_legal ? S_EXECUTE : w_after_instr;
            S_EXECUTE: begin
                if (w_is_rtype || w_is_addi) begin
                    w_next_state = S_WRITEBACK;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = w_after_instr;
                end
            end
            S_MEM:       w_next_state = w_is_lw ? S_WRITEBACK : w_after_instr;
            S_WRITEBACK: w_next_state = w_after_instr;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_pcsrc    = 2'b00;
        w_alusrcb  = 2'b00;
        w_aluctl   = 3'b000;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
                w_aluctl  = ALU_ADD;
            end
            S_DECODE: begin
                // ALU computes PC+imm*4 speculatively for a possible branch.
                w_alusrcb = 2'b11;
                w_aluctl  = ALU_ADD;
                w_illegal = ~w_legal;
            end
            S_EXECUTE: begin
                if (w_is_rtype) begin
                    w_alusrca = 1'b1;
                    w_aluctl  = w_rtype_alu;
                end else if (w_is_addi || w_is_lw || w_is_sw) begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                    w_aluctl  = ALU_ADD;
                end else if (w_is_beq || w_is_bne) begin
                    w_alusrca = 1'b1;
                    w_aluctl  = ALU_SUB;
                    w_pcsrc   = 2'b01;
                    w_pcwrite = w_is_beq ? zero : ~zero;
                    w_done    = 1'b1;
                end else if (w_is_j) begin
                    w_pcsrc   = 2'b10;
                    w_pcwrite = 1'b1;
                    w_done    = 1'b1;
                end
            end
            S_MEM: begin
                w_iord     = 1'b1;
                w_memwrite = w_is_sw;
                w_done     = w_is_sw;
            end
            S_WRITEBACK: begin
                w_regwrite = 1'b1;
                w_regdst   = w_is_rtype;
                w_memtoreg = w_is_lw;
                w_done     = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is held so an abandoned instruction writes nothing.
    assign IorD       = reset & w_iord;
    assign IRWrite    = reset & w_irwrite;
    assign PCWrite    = reset & w_pcwrite;
    assign MemWrite   = reset & w_memwrite;
    assign RegWrite   = reset & w_regwrite;
    assign RegDst     = reset & w_regdst;
    assign MemtoReg   = reset & w_memtoreg;
    assign ALUSrcA    = reset & w_alusrca;
    assign PCSrc      = reset ? w_pcsrc   : 2'b00;
    assign ALUSrcB    = reset ? w_alusrcb : 2'b00;
    assign ALUControl = reset ? w_aluctl  : 3'b000;
    assign instr_done = reset & w_done;
    assign illegal    = reset & w_illegal;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr_count <= '0;
        end else if (w_done) begin
            r_instr_count <= r_instr_count + CNT_ONE;
        end
    end

    assign instr_count = r_instr_count;

endmodule
